wb_block_copy: RTL and testbench

- Wishbone-style single-outstanding master that copies a block of 32-bit words between two addresses through one port of dualportram (port A or port B).
- Used by controller logic to move or duplicate buffers inside the RAM without CPU involvement.
- It is the initiator for the dualportram port protocol: it drives stb/we/sel/addr/data, and honours stall and ack.

---
 rtl/wb_block_copy.sv | 204 ++++++++++++++++++++
 tb/tb_wb_block_copy.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_block_copy.sv
// rtl/wb_block_copy.sv - single-outstanding Wishbone master copying a block of words through one dualportram port
module wb_block_copy #(
    parameter int AW      = 11,
    parameter int DW      = 32,
    parameter int TIMEOUT = 16
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          start_i,
    input  logic [AW-1:0] src_addr_i,
    input  logic [AW-1:0] dst_addr_i,
    input  logic [AW:0]   len_i,
    output logic          busy_o,
    output logic          done_o,
    output logic          err_o,
    output logic [AW:0]   count_o,
    output logic          wb_stb_o,
    output logic          wb_we_o,
    output logic [3:0]    wb_sel_o,
    output logic [AW-1:0] wb_addr_o,
    output logic [DW-1:0] wb_data_o,
    input  logic [DW-1:0] wb_data_i,
    input  logic          wb_ack_i,
    input  logic          wb_stall_i
);

    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        IDLE,
        RD_REQ,
        RD_WAIT,
        WR_REQ,
        WR_WAIT,
        FINISH
    } state_t;

    state_t          state_q, state_d;
    logic [AW-1:0]   src_q, src_d;
    logic [AW-1:0]   dst_q, dst_d;
    logic [AW:0]     rem_q, rem_d;
    logic [AW:0]     count_q, count_d;
    logic [DW-1:0]   data_q, data_d;
    logic [TW-1:0]   timer_q, timer_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            err_q, err_d;
    logic            stb_q, stb_d;
    logic            we_q, we_d;
    logic [AW-1:0]   addr_q, addr_d;

    logic accept;
    logic timed_out;

    assign accept    = stb_q & ~wb_stall_i;
    assign timed_out = (timer_q == TW'(TIMEOUT - 1));

    always_comb begin
        state_d = state_q;
        src_d   = src_q;
        dst_d   = dst_q;
        rem_d   = rem_q;
        count_d = count_q;
        data_d  = data_q;
        timer_d = timer_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        err_d   = err_q;
        stb_d   = stb_q;
        we_d    = we_q;
        addr_d  = addr_q;

        case (state_q)
            IDLE: begin
                if (start_i) begin
                    src_d   = src_addr_i;
                    dst_d   = dst_addr_i;
                    rem_d   = len_i;
                    count_d = '0;
                    err_d   = 1'b0;
                    if (len_i == '0) begin
                        // done and busy are registered with the state, so FINISH shows done=1, busy=0
                        state_d = FINISH;
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                    end else begin
                        state_d = RD_REQ;
                        busy_d  = 1'b1;
                        stb_d   = 1'b1;
                        we_d    = 1'b0;
                        addr_d  = src_addr_i;
                    end
                end
            end
            RD_REQ: begin
                if (accept) begin
                    stb_d   = 1'b0;
                    timer_d = '0;
                    state_d = RD_WAIT;
                end
            end
            RD_WAIT: begin
                if (wb_ack_i) begin
                    data_d  = wb_data_i;
                    state_d = WR_REQ;
                    stb_d   = 1'b1;
                    we_d    = 1'b1;
                    addr_d  = dst_q;
                end else if (timed_out) begin
                    err_d   = 1'b1;
                    state_d = FINISH;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            WR_REQ: begin
                if (accept) begin
                    stb_d   = 1'b0;
                    timer_d = '0;
                    state_d = WR_WAIT;
                end
            end
            WR_WAIT: begin
                if (wb_ack_i) begin
                    count_d = count_q + 1'b1;
                    src_d   = src_q + 1'b1;
                    dst_d   = dst_q + 1'b1;
                    rem_d   = rem_q - 1'b1;
                    if (rem_q == (AW+1)'(1)) begin
                        state_d = FINISH;
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                    end else begin
                        state_d = RD_REQ;
                        stb_d   = 1'b1;
                        we_d    = 1'b0;
                        addr_d  = src_q + 1'b1;
                    end
                end else if (timed_out) begin
                    err_d   = 1'b1;
                    state_d = FINISH;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            FINISH: begin
                we_d    = 1'b0;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                stb_d   = 1'b0;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            src_q   <= '0;
            dst_q   <= '0;
            rem_q   <= '0;
            count_q <= '0;
            data_q  <= '0;
            timer_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            stb_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
        end else begin
            state_q <= state_d;
            src_q   <= src_d;
            dst_q   <= dst_d;
            rem_q   <= rem_d;
            count_q <= count_d;
            data_q  <= data_d;
            timer_q <= timer_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
            stb_q   <= stb_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
        end
    end

    assign busy_o    = busy_q;
    assign done_o    = done_q;
    assign err_o     = err_q;
    assign count_o   = count_q;
    assign wb_stb_o  = stb_q;
    assign wb_we_o   = we_q;
    assign wb_sel_o  = 4'b1111;
    assign wb_addr_o = addr_q;
    assign wb_data_o = data_q;

endmodule

// File: tb/tb_wb_block_copy.sv
// tb/tb_wb_block_copy.sv - self-checking bench for wb_block_copy with a RAM slave model
`timescale 1ns/1ps
module tb_wb_block_copy;
    localparam int AW   = 11;
    localparam int DW   = 32;
    localparam int TO   = 16;
    localparam int MEMW = 1 << AW;

    typedef struct {
        logic [AW-1:0] src;
        logic [AW-1:0] dst;
        logic [AW:0]   len;
        int            exp_lat;
        int            exp_cnt;
    } vec_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start_i = 1'b0;
    logic [AW-1:0] src_addr = '0;
    logic [AW-1:0] dst_addr = '0;
    logic [AW:0]   len_v = '0;
    logic          busy_o, done_o, err_o;
    logic [AW:0]   count_o;
    logic          wb_stb_o, wb_we_o;
    logic [3:0]    wb_sel_o;
    logic [AW-1:0] wb_addr_o;
    logic [DW-1:0] wb_data_o;
    logic [DW-1:0] wb_data_i = '0;
    logic          wb_ack_i = 1'b0;
    logic          wb_stall_i = 1'b0;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    logic [DW-1:0] mem     [MEMW];
    logic [DW-1:0] exp_mem [MEMW];

    bit            acc_pend = 0;
    logic [AW-1:0] acc_addr = '0;
    logic          acc_we = 1'b0;
    logic [DW-1:0] acc_data = '0;
    int            req_idx = 0;
    int            supp_idx = -1;
    int            acc_cyc = -1;
    int            stall_wr_left = 0;
    int            stall_cnt = 0;
    int            unstable = 0;
    bit            stall_watch = 0;
    bit            rnd_stall = 0;
    logic [AW-1:0] st_addr = '0;
    logic [DW-1:0] st_data = '0;
    int            first_err = -1;
    int            start_cyc = 0;
    int            rd_log[$];
    int            wr_log[$];

    wb_block_copy #(.AW(AW), .DW(DW), .TIMEOUT(TO)) dut (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .start_i    (start_i),
        .src_addr_i (src_addr),
        .dst_addr_i (dst_addr),
        .len_i      (len_v),
        .busy_o     (busy_o),
        .done_o     (done_o),
        .err_o      (err_o),
        .count_o    (count_o),
        .wb_stb_o   (wb_stb_o),
        .wb_we_o    (wb_we_o),
        .wb_sel_o   (wb_sel_o),
        .wb_addr_o  (wb_addr_o),
        .wb_data_o  (wb_data_o),
        .wb_data_i  (wb_data_i),
        .wb_ack_i   (wb_ack_i),
        .wb_stall_i (wb_stall_i)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // RAM slave: decides stall at the falling edge, acks one cycle after acceptance
    always @(negedge clk) begin
        wb_ack_i  = 1'b0;
        wb_data_i = $urandom;
        if (!rst_n) begin
            acc_pend   = 0;
            wb_stall_i = 1'b0;
        end else begin
            if (acc_pend) begin
                if (req_idx != supp_idx) begin
                    wb_ack_i = 1'b1;
                    if (acc_we) begin
                        mem[acc_addr] = acc_data;
                        wr_log.push_back(int'(acc_addr));
                    end else begin
                        wb_data_i = mem[acc_addr];
                        rd_log.push_back(int'(acc_addr));
                    end
                end
                req_idx++;
                acc_pend = 0;
            end
            wb_stall_i = 1'b0;
            if (wb_stb_o) begin
                if (stall_watch && (wb_addr_o != st_addr || wb_data_o != st_data))
                    unstable++;
                if (stall_wr_left > 0 && wb_we_o) begin
                    if (!stall_watch) begin
                        st_addr     = wb_addr_o;
                        st_data     = wb_data_o;
                        stall_watch = 1;
                    end
                    wb_stall_i = 1'b1;
                    stall_wr_left--;
                end else if (rnd_stall && $urandom_range(0, 2) == 0) begin
                    wb_stall_i = 1'b1;
                end
                if (wb_stall_i) begin
                    stall_cnt++;
                end else begin
                    stall_watch = 0;
                    acc_pend    = 1;
                    acc_addr    = wb_addr_o;
                    acc_we      = wb_we_o;
                    acc_data    = wb_data_o;
                    if (req_idx == supp_idx) acc_cyc = cyc + 1;
                end
            end
        end
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", nm, act, exp);
        end
    endtask

    task automatic launch(input logic [AW-1:0] s, input logic [AW-1:0] d, input logic [AW:0] l);
        req_idx     = 0;
        stall_cnt   = 0;
        unstable    = 0;
        stall_watch = 0;
        first_err   = -1;
        acc_cyc     = -1;
        rd_log.delete();
        wr_log.delete();
        @(negedge clk);
        src_addr = s;
        dst_addr = d;
        len_v    = l;
        start_i  = 1'b1;
        @(posedge clk);
        #1;
        start_i   = 1'b0;
        start_cyc = cyc;
    endtask

    task automatic wait_done(output int lat);
        lat = -1;
        for (int n = 0; n < 4000; n++) begin
            if (err_o && first_err < 0) first_err = cyc;
            if (done_o) begin
                lat = cyc - start_cyc;
                break;
            end
            @(posedge clk);
            #1;
        end
        if (lat < 0) begin
            checks++;
            errors++;
            $display("FAIL done_wait actual=no_done expected=done_within_4000_cycles");
        end
    endtask

    task automatic run_and_check(input string tag, input logic [AW-1:0] s, input logic [AW-1:0] d,
                                 input logic [AW:0] l, input int exp_base, input int exp_cnt);
        int lat;
        int bad;
        for (int i = 0; i < MEMW; i++) exp_mem[i] = mem[i];
        for (int i = 0; i < int'(l); i++)
            exp_mem[(int'(d) + i) % MEMW] = exp_mem[(int'(s) + i) % MEMW];
        launch(s, d, l);
        chk({tag, "_err_clear"}, 64'(err_o), 64'(0));
        chk({tag, "_busy"}, 64'(busy_o), 64'(l != 0));
        wait_done(lat);
        chk({tag, "_latency"}, 64'(lat), 64'(exp_base + stall_cnt));
        chk({tag, "_count"}, 64'(count_o), 64'(exp_cnt));
        chk({tag, "_err"}, 64'(err_o), 64'(0));
        @(posedge clk);
        #1;
        chk({tag, "_done_one_cycle"}, 64'({done_o, busy_o}), 64'(0));
        bad = 0;
        for (int i = 0; i < MEMW; i++) if (mem[i] !== exp_mem[i]) bad++;
        chk({tag, "_mem_bad_words"}, 64'(bad), 64'(0));
        bad = 0;
        if (rd_log.size() != int'(l) || wr_log.size() != int'(l)) bad++;
        else for (int i = 0; i < int'(l); i++) begin
            if (rd_log[i] != (int'(s) + i) % MEMW) bad++;
            if (wr_log[i] != (int'(d) + i) % MEMW) bad++;
        end
        chk({tag, "_addr_seq_bad"}, 64'(bad), 64'(0));
    endtask

    vec_t tbl [4];

    initial begin
        int lat;
        logic [DW-1:0] src_word;
        logic [AW-1:0] rs, rd;
        logic [AW:0]   rl;

        tbl[0] = '{11'h100, 11'h400, 12'd4, 16, 4};
        tbl[1] = '{11'h200, 11'h300, 12'd0, 0, 0};
        tbl[2] = '{11'h7FE, 11'h010, 12'd3, 12, 3};
        tbl[3] = '{11'h050, 11'h052, 12'd5, 20, 5};

        for (int i = 0; i < MEMW; i++) mem[i] = $urandom;
        for (int i = 0; i < 4; i++) mem[11'h100 + i] = 32'hA0 + i;

        repeat (3) @(posedge clk);
        #1;
        chk("reset_ctrl", 64'({busy_o, done_o, err_o, wb_stb_o, wb_we_o}), 64'(0));
        chk("reset_count", 64'(count_o), 64'(0));
        chk("reset_addr_data", 64'({wb_addr_o, wb_data_o}), 64'(0));
        chk("reset_sel", 64'(wb_sel_o), 64'(4'b1111));
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 4; i++)
            run_and_check($sformatf("vec%0d", i), tbl[i].src, tbl[i].dst, tbl[i].len,
                          tbl[i].exp_lat, tbl[i].exp_cnt);
        chk("vec0_word3", 64'(mem[11'h403]), 64'(32'hA3));

        stall_wr_left = 3;
        run_and_check("stall", 11'h140, 11'h440, 12'd4, 16, 4);
        chk("stall_cycles", 64'(stall_cnt), 64'(3));
        chk("stall_stable", 64'(unstable), 64'(0));

        supp_idx = 2;
        src_word = mem[11'h120];
        launch(11'h120, 11'h500, 12'd4);
        wait_done(lat);
        chk("to_err_delay", 64'(first_err - acc_cyc), 64'(TO));
        chk("to_done_with_err", 64'(lat), 64'(first_err - start_cyc));
        chk("to_count", 64'(count_o), 64'(1));
        chk("to_word0", 64'(mem[11'h500]), 64'(src_word));
        @(posedge clk);
        #1;
        chk("to_err_sticky", 64'({err_o, done_o}), 64'(2'b10));
        supp_idx = -1;
        run_and_check("after_to", 11'h130, 11'h530, 12'd2, 8, 2);

        launch(11'h600, 11'h680, 12'd8);
        for (int n = 0; n < 200 && count_o != 3; n++) begin
            @(posedge clk);
            #1;
        end
        chk("rst_reach_word3", 64'(count_o), 64'(3));
        for (int n = 0; n < 20 && !wb_stb_o; n++) begin
            @(posedge clk);
            #1;
        end
        chk("rst_stb_before", 64'(wb_stb_o), 64'(1));
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_async_drop", 64'({wb_stb_o, busy_o}), 64'(0));
        for (int n = 0; n < 3; n++) begin
            @(posedge clk);
            #1;
            chk("rst_no_done", 64'({done_o, wb_stb_o, count_o}), 64'(0));
        end
        @(negedge clk);
        #1;
        rst_n = 1'b1;
        run_and_check("post_rst", 11'h600, 11'h6A0, 12'd4, 16, 4);

        rnd_stall = 1;
        for (int k = 0; k < 6; k++) begin
            rs = AW'($urandom);
            rd = AW'($urandom);
            rl = (AW+1)'($urandom_range(1, 20));
            run_and_check($sformatf("rnd%0d", k), rs, rd, rl, 4 * int'(rl), int'(rl));
        end
        rnd_stall = 0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
